// File: rtl/burst_cacheline_adaptor_pkg.sv
// Shared types and sizing for the cacheline <-> burst adaptor.
package burst_cacheline_adaptor_pkg;

  localparam int CACHELINE_W = 256;
  localparam int BURST_W     = 64;
  localparam int BURST_BEATS = CACHELINE_W / BURST_W;
  localparam int CNT_W       = $clog2(BURST_BEATS);
  localparam int BEAT_IDX_W  = $clog2(BURST_W);
  localparam int LINE_IDX_W  = $clog2(CACHELINE_W);
  localparam int OFFSET_BITS = $clog2(CACHELINE_W / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;

  // Bit offset of beat c inside the line (beat 0 is the low slice).
  function automatic logic [LINE_IDX_W-1:0] beat_base(input logic [CNT_W-1:0] c);
    return {c, {BEAT_IDX_W{1'b0}}};
  endfunction

endpackage

// File: rtl/burst_cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the adaptor.
interface burst_cacheline_adaptor_if;
  import burst_cacheline_adaptor_pkg::*;

  logic [CACHELINE_W-1:0] line_i;
  logic [CACHELINE_W-1:0] line_o;
  logic [31:0]            address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_W-1:0]     burst_i;
  logic [BURST_W-1:0]     burst_o;
  logic [31:0]            address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  // Adaptor side.
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  // Environment side: cache requester plus physical memory.
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/burst_cacheline_adaptor.sv
// Splits a 256-bit cacheline transfer into a 4x64-bit memory burst and
// reassembles read beats; returns a one-cycle line response to the cache.
module burst_cacheline_adaptor
  import burst_cacheline_adaptor_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  burst_cacheline_adaptor_if.slave  bus
);

  adaptor_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [CACHELINE_W-1:0] rbuf_q, rbuf_d;
  logic [CACHELINE_W-1:0] wline_q, wline_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rbuf_q  <= '0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rbuf_q  <= rbuf_d;
      wline_q <= wline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rbuf_d  = rbuf_q;
    wline_d = wline_q;
    unique case (state_q)
      IDLE: begin
        // Write takes priority when both requests are raised together.
        if (bus.write_i) begin
          state_d = WRITE;
          addr_d  = bus.address_i & ADDR_MASK;
          wline_d = bus.line_i;
          cnt_d   = '0;
        end else if (bus.read_i) begin
          state_d = READ;
          addr_d  = bus.address_i & ADDR_MASK;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          rbuf_d[beat_base(cnt_q) +: BURST_W] = bus.burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a decode of registered state; nothing flows through from inputs.
  assign bus.read_o    = (state_q == READ);
  assign bus.write_o   = (state_q == WRITE);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = addr_q;
  assign bus.line_o    = rbuf_q;
  assign bus.burst_o   = (state_q == WRITE) ? wline_q[beat_base(cnt_q) +: BURST_W] : '0;

endmodule

// File: tb/tb_burst_cacheline_adaptor.sv
// Directed bench for burst_cacheline_adaptor: reads, writes, gaps, priority, reset, back-to-back.
module tb_burst_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  burst_cacheline_adaptor_if bus();

  burst_cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] rb [4];
  logic [63:0] wb [4];
  logic [63:0] gb [4];
  logic [255:0] line_read1, line_gap;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    tick; tick;
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL reset_read_o got=%b exp=0", bus.read_o); end
    checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL reset_write_o got=%b exp=0", bus.write_o); end
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL reset_resp_o got=%b exp=0", bus.resp_o); end
    checks++; if (bus.address_o !== 32'h0) begin failures++; $display("FAIL reset_address_o got=%h exp=0", bus.address_o); end
    checks++; if (bus.burst_o !== 64'h0) begin failures++; $display("FAIL reset_burst_o got=%h exp=0", bus.burst_o); end
    checks++; if (bus.line_o !== 256'h0) begin failures++; $display("FAIL reset_line_o got=%h exp=0", bus.line_o); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_read;
    bus.address_i = 32'h0000_1234; bus.read_i = 1;
    tick;
    checks++; if (bus.address_o !== 32'h0000_1220) begin failures++; $display("FAIL read_address_o got=%h exp=00001220", bus.address_o); end
    checks++; if (bus.write_o !== 1'b0) begin failures++; $display("FAIL read_write_o got=%b exp=0", bus.write_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin failures++; $display("FAIL read_beat%0d_read_o/resp_o got=%b/%b exp=1/0", i, bus.read_o, bus.resp_o); end
      bus.resp_i = 1; bus.burst_i = rb[i];
      tick;
    end
    bus.resp_i = 0; bus.burst_i = '0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL read_resp_o got=%b exp=1", bus.resp_o); end
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL read_done_read_o got=%b exp=0", bus.read_o); end
    checks++; if (bus.line_o !== line_read1) begin failures++; $display("FAIL read_line_o got=%h exp=%h", bus.line_o, line_read1); end
    tick;
    bus.read_i = 0;
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL read_resp_single got=%b exp=0", bus.resp_o); end
    tick;
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL read_no_restart got=%b exp=0", bus.read_o); end
  endtask

  task automatic test_write;
    bus.line_i = {wb[3], wb[2], wb[1], wb[0]}; bus.address_i = 32'h8000_0040; bus.write_i = 1;
    tick;
    checks++; if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0) begin failures++; $display("FAIL write_start write_o/read_o got=%b/%b exp=1/0", bus.write_o, bus.read_o); end
    checks++; if (bus.address_o !== 32'h8000_0040) begin failures++; $display("FAIL write_address_o got=%h exp=80000040", bus.address_o); end
    checks++; if (bus.burst_o !== wb[0]) begin failures++; $display("FAIL write_beat0_pre got=%h exp=%h", bus.burst_o, wb[0]); end
    tick;
    // inputs change after latching must not leak into the burst
    bus.line_i = '1; bus.address_i = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.burst_o !== wb[i] || bus.write_o !== 1'b1) begin failures++; $display("FAIL write_beat%0d got=%h/%b exp=%h/1", i, bus.burst_o, bus.write_o, wb[i]); end
      bus.resp_i = 1;
      tick;
    end
    bus.resp_i = 0;
    checks++; if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin failures++; $display("FAIL write_done resp_o/write_o got=%b/%b exp=1/0", bus.resp_o, bus.write_o); end
    checks++; if (bus.address_o !== 32'h8000_0040) begin failures++; $display("FAIL write_addr_hold got=%h exp=80000040", bus.address_o); end
    checks++; if (bus.line_o !== line_read1) begin failures++; $display("FAIL write_line_o_stable got=%h exp=%h", bus.line_o, line_read1); end
    tick;
    bus.write_i = 0;
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL write_resp_single got=%b exp=0", bus.resp_o); end
    tick;
  endtask

  task automatic test_gapped_read;
    logic pat [7];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    k = 0;
    bus.address_i = 32'h0000_2000; bus.read_i = 1;
    tick;
    for (int i = 0; i < 7; i++) begin
      checks++; if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin failures++; $display("FAIL gap_cycle%0d read_o/resp_o got=%b/%b exp=1/0", i, bus.read_o, bus.resp_o); end
      bus.resp_i = pat[i];
      if (pat[i]) begin bus.burst_i = gb[k]; k++; end
      else bus.burst_i = 64'hBADB_ADBA_DBAD_BADB;
      tick;
    end
    bus.resp_i = 0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL gap_resp_o got=%b exp=1", bus.resp_o); end
    checks++; if (bus.line_o !== line_gap) begin failures++; $display("FAIL gap_line_o got=%h exp=%h", bus.line_o, line_gap); end
    tick;
    bus.read_i = 0;
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL gap_resp_single got=%b exp=0", bus.resp_o); end
    tick;
  endtask

  task automatic test_simultaneous;
    bus.line_i = {wb[0], wb[1], wb[2], wb[3]}; bus.address_i = 32'h0000_0100;
    bus.read_i = 1; bus.write_i = 1;
    tick;
    checks++; if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0) begin failures++; $display("FAIL simul_priority write_o/read_o got=%b/%b exp=1/0", bus.write_o, bus.read_o); end
    checks++; if (bus.burst_o !== wb[3]) begin failures++; $display("FAIL simul_burst0 got=%h exp=%h", bus.burst_o, wb[3]); end
    for (int i = 0; i < 4; i++) begin bus.resp_i = 1; bus.burst_i = 64'hFFFF_0000_FFFF_0000; tick; end
    bus.resp_i = 0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL simul_resp_o got=%b exp=1", bus.resp_o); end
    tick;
    bus.read_i = 0; bus.write_i = 0;
    tick;
    bus.resp_i = 1; bus.burst_i = 64'h5555_AAAA_5555_AAAA;
    tick; tick;
    checks++; if (bus.line_o !== line_gap) begin failures++; $display("FAIL stray_line_o got=%h exp=%h", bus.line_o, line_gap); end
    checks++; if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin failures++; $display("FAIL stray_idle r/w/resp got=%b/%b/%b exp=0/0/0", bus.read_o, bus.write_o, bus.resp_o); end
    bus.resp_i = 0; bus.burst_i = '0;
    tick;
  endtask

  task automatic test_reset_mid_read;
    bus.address_i = 32'h0000_3000; bus.read_i = 1;
    tick;
    for (int i = 0; i < 2; i++) begin bus.resp_i = 1; bus.burst_i = rb[i]; tick; end
    rst = 1'b0;
    #1;
    checks++; if (bus.read_o !== 1'b0) begin failures++; $display("FAIL rstmid_read_o got=%b exp=0", bus.read_o); end
    checks++; if (bus.line_o !== 256'h0) begin failures++; $display("FAIL rstmid_line_o got=%h exp=0", bus.line_o); end
    checks++; if (bus.address_o !== 32'h0) begin failures++; $display("FAIL rstmid_address_o got=%h exp=0", bus.address_o); end
    bus.resp_i = 0; bus.read_i = 0; bus.burst_i = '0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0) begin failures++; $display("FAIL rstmid_idle%0d resp_o/read_o got=%b/%b exp=0/0", i, bus.resp_o, bus.read_o); end
    end
    bus.address_i = 32'h0000_301F; bus.read_i = 1;
    tick;
    checks++; if (bus.read_o !== 1'b1 || bus.address_o !== 32'h0000_3000) begin failures++; $display("FAIL rstmid_rerun_start got=%b/%h exp=1/00003000", bus.read_o, bus.address_o); end
    for (int i = 0; i < 4; i++) begin bus.resp_i = 1; bus.burst_i = rb[i]; tick; end
    bus.resp_i = 0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL rstmid_rerun_resp got=%b exp=1", bus.resp_o); end
    checks++; if (bus.line_o !== line_read1) begin failures++; $display("FAIL rstmid_rerun_line got=%h exp=%h", bus.line_o, line_read1); end
    tick;
    bus.read_i = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    bus.address_i = 32'h0000_4000; bus.read_i = 1;
    tick;
    for (int i = 0; i < 4; i++) begin bus.resp_i = 1; bus.burst_i = gb[i]; tick; end
    bus.resp_i = 0;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL b2b_read_resp got=%b exp=1", bus.resp_o); end
    checks++; if (bus.line_o !== line_gap) begin failures++; $display("FAIL b2b_read_line got=%h exp=%h", bus.line_o, line_gap); end
    t1 = cyc;
    tick;
    bus.read_i = 0; bus.write_i = 1; bus.address_i = 32'h0000_5000;
    bus.line_i = {wb[3], wb[2], wb[1], wb[0]};
    checks++; if (bus.resp_o !== 1'b0) begin failures++; $display("FAIL b2b_gap_resp got=%b exp=0", bus.resp_o); end
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.write_o !== 1'b1 || bus.burst_o !== wb[i]) begin failures++; $display("FAIL b2b_wbeat%0d got=%b/%h exp=1/%h", i, bus.write_o, bus.burst_o, wb[i]); end
      bus.resp_i = 1;
      tick;
    end
    bus.resp_i = 0;
    t2 = cyc;
    checks++; if (bus.resp_o !== 1'b1) begin failures++; $display("FAIL b2b_write_resp got=%b exp=1", bus.resp_o); end
    checks++; if ((t2 - t1) !== 6) begin failures++; $display("FAIL b2b_spacing got=%0d exp=6", t2 - t1); end
    tick;
    bus.write_i = 0;
    tick;
  endtask

  initial begin
    rb[0] = 64'h1111_1111_1111_1111; rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333; rb[3] = 64'h4444_4444_4444_4444;
    wb[0] = 64'hDEAD_BEEF_0000_0000; wb[1] = 64'hDEAD_BEEF_1111_0001;
    wb[2] = 64'hDEAD_BEEF_2222_0002; wb[3] = 64'hDEAD_BEEF_3333_0003;
    gb[0] = 64'h0123_4567_89AB_CDEF; gb[1] = 64'hFEDC_BA98_7654_3210;
    gb[2] = 64'hA5A5_A5A5_5A5A_5A5A; gb[3] = 64'h0F0F_F0F0_0F0F_F0F0;
    line_read1 = {rb[3], rb[2], rb[1], rb[0]};
    line_gap   = {gb[3], gb[2], gb[1], gb[0]};
    test_reset;
    test_read;
    test_write;
    test_gapped_read;
    test_simultaneous;
    test_reset_mid_read;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_cacheline_adaptor.md
# burst_cacheline_adaptor

Downstream neighbour of the pipelined cache: converts one 256-bit cacheline read or write from the cache's memory port into a 4-beat, 64-bit burst on the physical-memory bus. It reassembles read bursts into a full line and slices write lines into beats. It then returns a single-cycle line response to the cache.

## Interface
- s_line, 256, cacheline width (bits)
- s_beat, 64, burst beat width (bits); s_line must be an exact multiple
- s_beats, s_line/s_beat (=4), beats per line, derived
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- line_i  in  s_line  write line from cache (cache pmem_wdata)
- line_o  out  s_line  assembled read line (cache pmem_rdata)
- address_i  in  32  line address from cache (cache pmem_address)
- read_i  in  1  line read request, held until resp_o
- write_i  in  1  line write request, held until resp_o
- resp_o  out  1  line transfer complete, one cycle
- burst_i  in  s_beat  read beat from memory
- burst_o  out  s_beat  write beat to memory
- address_o  out  32  burst base address, {address[31:5], 5'b0}
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  memory beat strobe; one beat per high cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: when write_i=1, latch address_i (offset bits zeroed) and line_i, clear beat counter, go to WRITE. Otherwise, when read_i=1, latch address, clear counter, go to READ. If write_i and read_i are both high, write wins.
- READ: read_o=1. On each resp_i=1, store burst_i into line buffer slice [count*64 +: 64] and increment the counter. When resp_i arrives with count=3, go to DONE.
- WRITE: write_o=1 and burst_o=latched line slice [count*64 +: 64]. On each resp_i=1, increment the counter. When resp_i arrives with count=3, go to DONE.
- DONE: resp_o=1 for exactly one cycle, then IDLE.
- Beat order is low slice first: beat 0 = bits 63:0, beat 3 = bits 255:192.
- line_o is driven from the line buffer. It is stable from DONE until the next read's first beat.
- Gaps are legal: resp_i may drop between beats. The counter holds, and read_o/write_o stay asserted.
- resp_i in IDLE or DONE is ignored.
- Changes on address_i, line_i, read_i or write_i after latching are ignored until IDLE.
- Requester drops read_i/write_i on the cycle after resp_o. A request still high in the IDLE following DONE starts a new transfer.
- Counter is 2 bits and wraps only via the DONE transition, never mid-burst.

## Timing
- Reset: state=IDLE, counter=0, line buffer=0, latched address=0, all outputs 0 (resp_o, read_o, write_o, address_o, burst_o, line_o).
- Reset asserted mid-burst aborts immediately. read_o/write_o drop asynchronously, and no resp_o is issued.
- read_o, write_o, resp_o and address_o decode from registered state and latches only. There is no combinational path from any input.
- Request at cycle 0 (IDLE): read_o/write_o high from cycle 1.
- Back-to-back resp_i in cycles 1-4 gives resp_o in cycle 5; minimum latency is 5 cycles.
- Each gap cycle adds one cycle of latency.
- Turnaround: next request is accepted in the IDLE cycle after DONE, so there is a minimum of 6 cycles between line completions.

## Structure
- rv32i_types gains:
  - adaptor_state_t enum {IDLE, READ, WRITE, DONE}
  - constants CACHELINE_W=256, BURST_W=64, BURST_BEATS=4
- Single flat module; the 2-bit beat counter and line buffer are inline.
- No sub-module is warranted.

## Test plan
- Read, no gaps: read_i with address_i=0x0000_1234. Requires address_o=0x0000_1220 and read_o high from cycle 1. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 in cycles 1-4 give resp_o in cycle 5 and line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write: line_i=0xDEAD...(4 distinct 64-bit words), address_i=0x8000_0040. Requires burst_o to present word 0 until the first resp_i, then words 1, 2 and 3. write_o drops in DONE, and resp_o is a single cycle.
- Gapped read: resp_i pattern 1,0,0,1,1,0,1. Requires read_o held throughout, correct 4-word assembly and resp_o exactly 1 cycle after the 4th beat.
- Simultaneous read_i=write_i=1 in IDLE: requires WRITE path taken (write_o=1, read_o=0). Stray resp_i in IDLE leaves state and line_o unchanged.
- Reset mid-read after 2 beats: requires read_o=0 immediately, line_o=0, state IDLE, and no resp_o. A subsequent read completes normally.
- Back-to-back: read then write, with each request held until resp_o and re-raised in the following IDLE cycle. Requires both to complete with resp_o pulses 6 cycles apart when no gaps occur.
